// File: rtl/instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit
//
// Fetch stage of the pipeline. It produces the instruction word, its address
// and the load enable for the IF/ID pipeline register. The PC/nPC pair gives
// MIPS delay-slot behaviour: the instruction already in fetch when a branch
// resolves in ID is always delivered, and the redirect applies to the PC after
// it. One fetched word is buffered while the hazard unit stalls, and a taken
// branch that cannot act yet is latched until the next delivery.
//
// Parameters:
//   RESET_PC         PC value loaded on reset
//   PC_STEP          byte increment between sequential instructions
//
// Ports:
//   Clk              clock, rising edge
//   Reset            asynchronous active-low reset
//   Stall            hazard unit: IF/ID must hold this cycle
//   Branch_Taken     one-cycle pulse from ID: the branch/jump in ID is taken
//   Branch_Target    redirect address, valid with Branch_Taken
//   IMEM_READY       instruction memory: IMEM_DATA is valid for IMEM_ADDR
//   IMEM_DATA        fetched instruction word
//   IMEM_REQ         fetch request
//   IMEM_ADDR        fetch address (the current PC)
//   IF_INSTR         instruction to the IF/ID DS input
//   IF_PC            address of IF_INSTR, to the IF/ID PC input
//   IF_LE            load enable to IF/ID (one delivered instruction)
//   Redirect_Pending a taken branch is latched but not yet applied
// ---------------------------------------------------------------------------
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Stall,
    input  logic        Branch_Taken,
    input  logic [31:0] Branch_Target,
    input  logic        IMEM_READY,
    input  logic [31:0] IMEM_DATA,
    output logic        IMEM_REQ,
    output logic [31:0] IMEM_ADDR,
    output logic [31:0] IF_INSTR,
    output logic [31:0] IF_PC,
    output logic        IF_LE,
    output logic        Redirect_Pending
);

    // FETCH: a request is outstanding for PC.
    // HOLD:  the word for PC was returned during a stall and is buffered.
    typedef enum logic [0:0] {
        ST_FETCH = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    state_t      state_q,       state_d;
    logic [31:0] pc_q,          pc_d;
    logic [31:0] npc_q,         npc_d;
    logic [31:0] hold_instr_q,  hold_instr_d;
    logic [31:0] hold_pc_q,     hold_pc_d;
    logic        pend_q,        pend_d;
    logic [31:0] pend_target_q, pend_target_d;

    logic        deliver;

    // Output decode. Everything is gated by Reset directly so that asserting
    // reset drops the request and the load enable immediately, without
    // waiting for the flops to be cleared by an edge.
    always_comb begin
        IMEM_REQ         = 1'b0;
        IMEM_ADDR        = pc_q;
        IF_INSTR         = 32'h0000_0000;
        IF_PC            = 32'h0000_0000;
        IF_LE            = 1'b0;
        Redirect_Pending = 1'b0;

        if (Reset) begin
            Redirect_Pending = pend_q;
            unique case (state_q)
                ST_FETCH: begin
                    IMEM_REQ = 1'b1;
                    IF_INSTR = IMEM_DATA;
                    IF_PC    = pc_q;
                    IF_LE    = IMEM_READY & ~Stall;
                end
                ST_HOLD: begin
                    IF_INSTR = hold_instr_q;
                    IF_PC    = hold_pc_q;
                    IF_LE    = ~Stall;
                end
                default: begin
                    IMEM_REQ = 1'b0;
                end
            endcase
        end
    end

    assign deliver = IF_LE;

    // Next-state logic. A delivery always advances the PC pair; a latched
    // redirect takes priority over a branch arriving in the same cycle,
    // because the latched one belongs to an older branch whose delay slot is
    // the instruction being delivered now.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        npc_d         = npc_q;
        hold_instr_d  = hold_instr_q;
        hold_pc_d     = hold_pc_q;
        pend_d        = pend_q;
        pend_target_d = pend_target_q;

        if (deliver) begin
            state_d = ST_FETCH;
            if (pend_q) begin
                pc_d   = pend_target_q;
                npc_d  = pend_target_q + PC_STEP;
                pend_d = 1'b0;
            end else if (Branch_Taken) begin
                pc_d   = Branch_Target;
                npc_d  = Branch_Target + PC_STEP;
            end else begin
                pc_d   = npc_q;
                npc_d  = npc_q + PC_STEP;
            end
        end else begin
            // Memory answered while IF/ID is stalled: park the word so the
            // request can be dropped, and keep PC pointing at it.
            if (state_q == ST_FETCH && IMEM_READY && Stall) begin
                state_d      = ST_HOLD;
                hold_instr_d = IMEM_DATA;
                hold_pc_d    = pc_q;
            end
            // A redirect that cannot act yet is remembered; a later one
            // replaces an earlier one.
            if (Branch_Taken) begin
                pend_d        = 1'b1;
                pend_target_d = Branch_Target;
            end
        end
    end

    // State register.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q       <= ST_FETCH;
            pc_q          <= RESET_PC;
            npc_q         <= RESET_PC + PC_STEP;
            hold_instr_q  <= 32'h0000_0000;
            hold_pc_q     <= 32'h0000_0000;
            pend_q        <= 1'b0;
            pend_target_q <= 32'h0000_0000;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            npc_q         <= npc_d;
            hold_instr_q  <= hold_instr_d;
            hold_pc_q     <= hold_pc_d;
            pend_q        <= pend_d;
            pend_target_q <= pend_target_d;
        end
    end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
Fetch stage transmitter that drives the IF/ID pipeline register's DS, PC and LE inputs. It sequences a PC/nPC pair with MIPS branch-delay-slot semantics and issues requests to instruction memory over a REQ/READY handshake. It buffers one fetched instruction while the hazard unit stalls, and applies taken-branch redirects from ID, latching them until they can take effect.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
PC_STEP, 4, byte increment between sequential instructions.

Ports:
Clk  input  1  clock, rising edge.
Reset  input  1  asynchronous, active-low reset.
Stall  input  1  hazard unit: 1 = IF/ID must hold (no LE pulse).
Branch_Taken  input  1  one-cycle pulse from ID: branch/jump in ID is taken.
Branch_Target  input  32  redirect address, valid with Branch_Taken.
IMEM_READY  input  1  instruction memory: IMEM_DATA valid for current IMEM_ADDR.
IMEM_DATA  input  32  fetched instruction word.
IMEM_REQ  output  1  fetch request.
IMEM_ADDR  output  32  fetch address (= PC).
IF_INSTR  output  32  instruction to IF/ID DS.
IF_PC  output  32  address of IF_INSTR, to IF/ID PC.
IF_LE  output  1  load enable to IF/ID.
Redirect_Pending  output  1  a taken branch is latched but not yet applied.

Behaviour:
- Reset (Reset=0, async): PC=RESET_PC, nPC=RESET_PC+PC_STEP, state=FETCH, hold_instr=0, hold_pc=0, pend=0, pend_target=0. Outputs while in reset: IMEM_REQ=0, IF_LE=0, IF_INSTR=0, IF_PC=0, Redirect_Pending=0. IMEM_REQ rises in the first cycle after Reset deasserts.
- Reset mid-fetch abandons any outstanding request. Memory tolerates REQ dropping without READY.
- States: FETCH, HOLD.
- FETCH:
  - IMEM_REQ=1, IMEM_ADDR=PC.
  - IF_INSTR=IMEM_DATA, IF_PC=PC.
  - IF_LE = IMEM_READY & ~Stall.
- HOLD:
  - IMEM_REQ=0.
  - IF_INSTR=hold_instr, IF_PC=hold_pc.
  - IF_LE=~Stall.
- Delivery: a cycle with IF_LE=1. At that Clk edge:
  - If pend=1: PC<=pend_target, nPC<=pend_target+PC_STEP, pend<=0.
  - Else if Branch_Taken=1 in the same cycle: PC<=Branch_Target, nPC<=Branch_Target+PC_STEP.
  - Else: PC<=nPC, nPC<=nPC+PC_STEP.
  - Next state is FETCH.
- FETCH & IMEM_READY & Stall: hold_instr<=IMEM_DATA, hold_pc<=PC, next state HOLD. PC is not advanced.
- FETCH & ~IMEM_READY: remain in FETCH, PC unchanged, IF_LE=0. There is no timeout.
- HOLD & Stall: remain in HOLD, all registers unchanged.
- Delay slot: when a branch at address B is in ID, the instruction in fetch is B+4 (the delay slot). It is always delivered, and the redirect applies to the PC *after* it. The unit never squashes the delay slot.
- Branch_Taken without delivery that cycle (stall, wait state or HOLD): pend<=1, pend_target<=Branch_Target.
- Branch_Taken while pend=1 and no delivery: newest wins, and pend_target is overwritten.
- Redirect_Pending = pend.
- Arithmetic: 32-bit unsigned, wraps modulo 2^32. For example, nPC after 32'hFFFF_FFFC is 32'h0000_0000. No alignment checks are made.
- Throughput: with zero-wait memory (READY in the REQ cycle) and no stall, one IF_LE per cycle, with zero cycles from address to IF/ID input.

Test Plan:
- Reset release, READY tied 1, Stall=0 -> IF_LE=1 every cycle, IF_PC sequence 0,4,8,12, IMEM_ADDR matches IF_PC.
- READY=0 for 3 cycles at PC=8, then 1 -> IMEM_ADDR holds 8 for 4 cycles, IF_LE=0 for 3 cycles then one pulse with IF_PC=8; next IMEM_ADDR=12.
- Stall=1 for 2 cycles while READY=1 at PC=16 (IMEM_DATA=32'h2001_0005) -> enters HOLD, IMEM_REQ=0. When Stall drops, IF_LE=1 with IF_INSTR=32'h2001_0005, IF_PC=16. Then fetch resumes at 20.
- Branch_Taken, Branch_Target=32'h100, while fetching PC=24 with no stall -> IF_PC sequence 24 (delay slot), then 0x100, 0x104.
- Branch_Taken, target 32'h200, during Stall with PC=24 -> Redirect_Pending=1. The delay slot at 24 is delivered after the stall, then IF_PC=0x200 and Redirect_Pending=0.
- RESET_PC=32'hFFFF_FFF8, no stall -> IF_PC sequence FFFF_FFF8, FFFF_FFFC, 0000_0000. Asserting Reset mid-WAIT drops IMEM_REQ and IF_LE to 0 immediately, without waiting for a clock edge.
